// File: rtl/dest_reg_bank.sv
// Destination register bank behind the 1-to-4 demux: stages the selected lane for one
// cycle, commits it to one of four registers, and exposes read, dirty and count state.
module dest_reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [3:0]       dirty,
  input  logic [3:0]       clr_dirty,
  output logic [7:0]       wr_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] stage_data;
  logic [1:0]       stage_idx;
  logic [WIDTH-1:0] lane;

  always_comb begin
    // NOTE: default assignment first so every path drives lane and no latch is inferred.
    lane = in0;
    case (wr_sel)
      2'd1:    lane = in1;
      2'd2:    lane = in2;
      2'd3:    lane = in3;
      default: lane = in0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so rd_data sees the
  // pre-edge register contents and a same-cycle commit is never bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ready   <= 1'b1;
      stage_data <= '0;
      stage_idx  <= '0;
      rd_data    <= '0;
      dirty      <= '0;
      wr_count   <= '0;
      // NOTE: the register file is architecturally visible, so it is reset explicitly;
      // the four entries stay in flops rather than a RAM macro.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      rd_data <= regs[rd_sel];
      case (state)
        IDLE: begin
          dirty <= dirty & ~clr_dirty;
          if (wr_valid) begin
            stage_data <= lane;
            stage_idx  <= wr_sel;
            state      <= BUSY;
            wr_ready   <= 1'b0;
          end
        end
        BUSY: begin
          // Commit set is OR-ed after the clear so it wins on the same bit.
          regs[stage_idx] <= stage_data;
          dirty           <= (dirty & ~clr_dirty) | (4'b0001 << stage_idx);
          wr_count        <= wr_count + 8'd1;
          state           <= IDLE;
          wr_ready        <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
